mul4_seq_ctrl: RTL and testbench

Sequential 4x4 unsigned shift-and-add multiplier controller. It time-shares a single 4-bit ripple-carry adder over four iterations to produce an 8-bit product. Operands are captured on a one-cycle `start`, and `done` pulses when the product is valid. The block sits between a requester (switch/button logic or a host FSM) and the 4-bit adder datapath built from `fulladder` cells.

---
 rtl/mul4_pkg.sv | 17 +
 rtl/adder4.sv | 33 +++
 rtl/fulladder.sv | 19 +
 rtl/mul4_seq_ctrl.sv | 98 +++++++++
 tb/tb_mul4_seq_ctrl.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/mul4_pkg.sv
// mul4_pkg: shared constants and FSM state type for the sequential
// 4x4 shift-and-add multiplier.
//   WIDTH       : operand width (datapath adder is fixed at 4 bits)
//   STEPS       : number of add/shift iterations per product
//   mul_state_t : controller states IDLE / CALC / DONE
package mul4_pkg;

  localparam int WIDTH = 4;
  localparam int STEPS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/adder4.sv
// adder4: 4-bit ripple-carry adder built from four chained fulladder cells.
// Ports:
//   a[3:0], b[3:0] : addends
//   cin            : carry into bit 0
//   s[3:0]         : sum
//   cout           : carry out of bit 3
module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  // w_c[i] is the carry into cell i; w_c[4] is the final carry out.
  logic [4:0] w_c;

  assign w_c[0] = cin;
  assign cout   = w_c[4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cell
      fulladder u_fa (
        .a    (a[gi]),
        .b    (b[gi]),
        .cin  (w_c[gi]),
        .s    (s[gi]),
        .cout (w_c[gi+1])
      );
    end
  endgenerate

endmodule

// File: rtl/fulladder.sv
// fulladder: single-bit full adder cell used to build the ripple adder.
// Ports:
//   a, b, cin : addend bits and carry in
//   s, cout   : sum bit and carry out
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_p;

  assign w_p  = a ^ b;
  assign s    = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);

endmodule

// File: rtl/mul4_seq_ctrl.sv
// mul4_seq_ctrl: sequential 4x4 unsigned shift-and-add multiplier.
// One 4-bit ripple adder is reused over four iterations; the 8-bit
// product is latched into p and announced by a one-cycle done pulse.
// Ports:
//   clk   : clock, all state changes on rising edge
//   rst   : synchronous active-high reset
//   start : request, honoured only in IDLE or DONE
//   a, b  : multiplicand / multiplier, captured on an accepted start
//   busy  : high while iterating (CALC)
//   done  : one-cycle pulse, p valid from this cycle on
//   p     : product register, held until next completion or reset
module mul4_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  import mul4_pkg::*;

  localparam logic [1:0] LAST_CNT = 2'(STEPS - 1);

  mul_state_t r_state;
  logic [3:0] r_mcand;
  logic [8:0] r_acc;
  logic [1:0] r_cnt;
  logic [7:0] r_p;

  logic [3:0] w_sum;
  logic       w_cout;
  logic [8:0] w_acc_next;
  logic       w_unused;

  // Bit 8 is a carry slot that every shift clears, so it is never consumed.
  assign w_unused = r_acc[8];

  adder4 u_adder (
    .a    (r_acc[7:4]),
    .b    (r_mcand),
    .cin  (1'b0),
    .s    (w_sum),
    .cout (w_cout)
  );

  // One iteration: optionally add the multiplicand into the high partial,
  // then shift the whole {carry, high, low} right by one. The carry-out
  // lands in bit 7 so it is never lost.
  always_comb begin
    w_acc_next = {2'b00, r_acc[7:4], r_acc[3:1]};
    if (r_acc[0]) begin
      w_acc_next = {1'b0, w_cout, w_sum, r_acc[3:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_mcand <= 4'h0;
      r_acc   <= 9'h000;
      r_cnt   <= 2'd0;
      r_p     <= 8'h00;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_mcand <= a[3:0];
            r_acc   <= {5'b00000, b[3:0]};
            r_cnt   <= 2'd0;
            r_state <= CALC;
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == LAST_CNT) begin
            r_p     <= w_acc_next[7:0];
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Moore outputs decoded straight from the state register.
  assign busy = (r_state == CALC);
  assign done = (r_state == DONE);
  assign p    = (2*WIDTH)'(r_p);

endmodule

// File: tb/tb_mul4_seq_ctrl.sv
module tb_mul4_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] p;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: edge number of the last accepted request and
  // the product it will deliver. Timing follows the latency rules:
  // busy for 4 cycles after the accepting edge, p/done at accept + 4.
  int         cyc      = 0;
  int         last_acc = -100;
  int         pend_p   = 0;
  int         exp_p    = 0;
  logic       saw_done;
  int         done_cyc_q[$];
  int         done_p_q[$];

  mul4_seq_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Advance one clock: update the model from the inputs seen at the edge,
  // then compare outputs on the falling edge.
  task automatic tick();
    int d;
    @(posedge clk);
    cyc++;
    if (rst) begin
      last_acc = -100;
      exp_p    = 0;
    end else begin
      d = cyc - last_acc;
      if (start && !(d >= 1 && d <= 4)) begin
        last_acc = cyc;
        pend_p   = int'(a) * int'(b);
      end
      if (cyc - last_acc == 4) exp_p = pend_p;
    end
    @(negedge clk);
    d = cyc - last_acc;
    chk("busy", {31'd0, busy}, {31'd0, (d >= 0 && d <= 3)});
    chk("done", {31'd0, done}, {31'd0, (d == 4)});
    chk("p", {24'd0, p}, exp_p);
    saw_done = done;
    if (done) begin
      done_cyc_q.push_back(cyc);
      done_p_q.push_back(int'(p));
      $display("txn cycle=%0d p=%0d", cyc, p);
    end
  endtask

  task automatic do_op(input logic [3:0] ta, input logic [3:0] tb_v, input int expp);
    start = 1'b1; a = ta; b = tb_v;
    tick();
    start = 1'b0;
    a = 4'($urandom); b = 4'($urandom);
    saw_done = 1'b0;
    for (int i = 0; i < 10 && !saw_done; i++) tick();
    if (!saw_done) chk("timeout_done", 0, 1);
    else           chk("op_product", {24'd0, p}, expp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_p", {24'd0, p}, 0);

    // Directed operand pairs
    do_op(4'd13, 4'd11, 143);
    do_op(4'd15, 4'd15, 225);
    do_op(4'd0,  4'd9,  0);
    do_op(4'd7,  4'd0,  0);
    tick();

    // Back-to-back with start held high; starts during busy are ignored
    done_cyc_q.delete();
    done_p_q.delete();
    start = 1'b1; a = 4'd3; b = 4'd5;
    tick();
    a = 4'd6; b = 4'd7;
    repeat (5) tick();
    start = 1'b0; a = 4'($urandom); b = 4'($urandom);
    repeat (6) tick();
    chk("b2b_count", done_cyc_q.size(), 2);
    if (done_cyc_q.size() == 2) begin
      chk("b2b_period", done_cyc_q[1] - done_cyc_q[0], 5);
      chk("b2b_p0", done_p_q[0], 15);
      chk("b2b_p1", done_p_q[1], 42);
    end

    // Reset during the second CALC cycle of 9*9 abandons the result
    start = 1'b1; a = 4'd9; b = 4'd9;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_done", {31'd0, done}, 0);
    chk("midrst_p", {24'd0, p}, 0);
    repeat (6) tick();
    chk("midrst_p_held", {24'd0, p}, 0);
    do_op(4'd2, 4'd3, 6);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 80) == 0);
      start = ($urandom_range(0, 2) == 0);
      a     = 4'($urandom_range(0, 15));
      b     = 4'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b0; start = 1'b0;
    repeat (6) tick();

    // Random single operations checked for the product value
    for (int i = 0; i < 20; i++) begin
      logic [3:0] ra, rb;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      do_op(ra, rb, int'(ra) * int'(rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
